piso_shift_register_8bit: RTL and testbench

Parallel-in, serial-out shift register. It is the transmit counterpart of shift_register_8bit (serial-in, parallel-out).
- Accepts a WIDTH-bit word through a valid/ready load handshake and buffers one further word in a holding register.
- Shifts the word out one bit per enabled clock, MSB first by default. Shifting is gated by SHIFT_ENABLE, the same way the receiver gates its shifting.
- Its DATA_OUT/SHIFT_ENABLE pair connects directly to the receiver's DATA_IN/SHIFT_ENABLE for serial loopback.

---
 rtl/piso_pkg.sv | 18 +
 rtl/piso_shift_register_8bit_chk.sv | 28 ++
 rtl/piso_shift_register_8bit.sv | 169 ++++++++++++++++
 tb/tb_piso_shift_register_8bit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in, serial-out transmitter.
package piso_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } piso_state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_register_8bit_chk.sv
// Structural invariants of the serial transmitter, observed on its registered outputs.
module piso_shift_register_8bit_chk #(
  parameter int CW = 3
) (
  input logic          clk,
  input logic          rst_n,
  input logic [CW-1:0] cnt,
  input logic [CW-1:0] cnt_last,
  input logic          data_out,
  input logic          bit_valid,
  input logic          busy,
  input logic          load_ready,
  input logic          word_done
);

  a_busy_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    busy == (bit_valid || !load_ready));

  a_idle_line_low: assert property (@(posedge clk) disable iff (!rst_n)
    !bit_valid |-> !data_out);

  a_cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= cnt_last);

  a_done_after_bit: assert property (@(posedge clk) disable iff (!rst_n)
    word_done |-> $past(bit_valid));

endmodule

// File: rtl/piso_shift_register_8bit.sv
// Parallel-in, serial-out shift register with a one-word holding buffer and
// valid/ready load handshake; DATA_OUT/SHIFT_ENABLE feed the matching receiver.
module piso_shift_register_8bit
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] PAR_IN,
  input  logic             SHIFT_ENABLE,
  output logic             DATA_OUT,
  output logic             BIT_VALID,
  output logic             BUSY,
  output logic             WORD_DONE
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

  piso_state_e      state_r,      nxt_state_s;
  logic [WIDTH-1:0] sreg_r,       nxt_sreg_s;
  logic [CW-1:0]    cnt_r,        nxt_cnt_s;
  logic [WIDTH-1:0] hold_r,       nxt_hold_s;
  logic             hold_valid_r, nxt_hold_valid_s;
  logic             nxt_done_s;
  logic             nxt_out_s;
  logic             accept_s;
  logic [WIDTH-1:0] shifted_s;

  logic data_out_r;
  logic bit_valid_r;
  logic busy_r;
  logic word_done_r;
  logic load_ready_r;

  // load_ready_r mirrors !hold_valid_r, so the handshake never depends on inputs combinationally
  assign accept_s = LOAD_VALID & load_ready_r;

  // Shift one position toward the output end, zero-filling the vacated bit
  always_comb begin
    if (MSB_FIRST) begin
      shifted_s = {sreg_r[WIDTH-2:0], 1'b0};
    end else begin
      shifted_s = {1'b0, sreg_r[WIDTH-1:1]};
    end
  end

  // Next-state logic for the shift core and the holding register
  always_comb begin
    nxt_state_s      = state_r;
    nxt_sreg_s       = sreg_r;
    nxt_cnt_s        = cnt_r;
    nxt_hold_s       = hold_r;
    nxt_hold_valid_s = hold_valid_r;
    nxt_done_s       = 1'b0;

    case (state_r)
      IDLE: begin
        if (hold_valid_r) begin
          nxt_sreg_s       = hold_r;
          nxt_hold_valid_s = 1'b0;
          nxt_cnt_s        = CNT_ZERO;
          nxt_state_s      = SHIFT;
        end else begin
          nxt_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (SHIFT_ENABLE) begin
          if (cnt_r == CNT_LAST) begin
            nxt_done_s = 1'b1;
            // Chain straight into the held word so the serial stream has no bubble
            if (hold_valid_r) begin
              nxt_sreg_s       = hold_r;
              nxt_hold_valid_s = 1'b0;
              nxt_cnt_s        = CNT_ZERO;
              nxt_state_s      = SHIFT;
            end else begin
              nxt_state_s = IDLE;
            end
          end else begin
            nxt_sreg_s = shifted_s;
            nxt_cnt_s  = cnt_r + CNT_ONE;
          end
        end else begin
          nxt_state_s = SHIFT;
        end
      end
      default: begin
        nxt_state_s = IDLE;
      end
    endcase

    // An accept only happens with the holder empty, so it never collides with a transfer
    if (accept_s) begin
      nxt_hold_s       = PAR_IN;
      nxt_hold_valid_s = 1'b1;
    end else begin
      nxt_hold_s = nxt_hold_s;
    end
  end

  // Serial bit presented after the coming edge; the line idles low
  always_comb begin
    if (nxt_state_s == SHIFT) begin
      if (MSB_FIRST) begin
        nxt_out_s = nxt_sreg_s[WIDTH-1];
      end else begin
        nxt_out_s = nxt_sreg_s[0];
      end
    end else begin
      nxt_out_s = 1'b0;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= IDLE;
      sreg_r       <= '0;
      cnt_r        <= CNT_ZERO;
      hold_r       <= '0;
      hold_valid_r <= 1'b0;
      data_out_r   <= 1'b0;
      bit_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      word_done_r  <= 1'b0;
      load_ready_r <= 1'b1;
    end else begin
      state_r      <= nxt_state_s;
      sreg_r       <= nxt_sreg_s;
      cnt_r        <= nxt_cnt_s;
      hold_r       <= nxt_hold_s;
      hold_valid_r <= nxt_hold_valid_s;
      data_out_r   <= nxt_out_s;
      bit_valid_r  <= (nxt_state_s == SHIFT);
      busy_r       <= (nxt_state_s == SHIFT) || nxt_hold_valid_s;
      word_done_r  <= nxt_done_s;
      load_ready_r <= !nxt_hold_valid_s;
    end
  end

  assign DATA_OUT   = data_out_r;
  assign BIT_VALID  = bit_valid_r;
  assign BUSY       = busy_r;
  assign WORD_DONE  = word_done_r;
  assign LOAD_READY = load_ready_r;

  piso_shift_register_8bit_chk #(
    .CW(CW)
  ) u_chk (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .cnt        (cnt_r),
    .cnt_last   (CNT_LAST),
    .data_out   (data_out_r),
    .bit_valid  (bit_valid_r),
    .busy       (busy_r),
    .load_ready (load_ready_r),
    .word_done  (word_done_r)
  );

endmodule

// File: tb/tb_piso_shift_register_8bit.sv
// Directed bench for the serial transmitter: MSB- and LSB-first instances share
// stimulus; a small receiver model closes the serial loopback.
module tb_piso_shift_register_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] par_in;
  logic       shift_en;

  logic load_ready_m, data_out_m, bit_valid_m, busy_m, word_done_m;
  logic load_ready_l, data_out_l, bit_valid_l, busy_l, word_done_l;

  logic [7:0] rx_q;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  load_q[$];
  int          acc_cyc[$];
  int          done_cyc[$];
  logic [31:0] bits;
  int          nbits;
  int          first_bit;
  int          last_bit;

  always #5 clk = ~clk;

  piso_shift_register_8bit #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .CLK(clk), .RESET_N(rst_n), .LOAD_VALID(load_valid), .LOAD_READY(load_ready_m),
    .PAR_IN(par_in), .SHIFT_ENABLE(shift_en), .DATA_OUT(data_out_m),
    .BIT_VALID(bit_valid_m), .BUSY(busy_m), .WORD_DONE(word_done_m)
  );

  piso_shift_register_8bit #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .CLK(clk), .RESET_N(rst_n), .LOAD_VALID(load_valid), .LOAD_READY(load_ready_l),
    .PAR_IN(par_in), .SHIFT_ENABLE(shift_en), .DATA_OUT(data_out_l),
    .BIT_VALID(bit_valid_l), .BUSY(busy_l), .WORD_DONE(word_done_l)
  );

  // Receiver model: left-shifting serial-in register gated by SHIFT_ENABLE && BIT_VALID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q <= 8'h00;
    end else if (shift_en && bit_valid_m) begin
      rx_q <= {rx_q[6:0], data_out_m};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data_out"},   {31'd0, data_out_m},   32'd0);
    check_eq({tag, "_bit_valid"},  {31'd0, bit_valid_m},  32'd0);
    check_eq({tag, "_busy"},       {31'd0, busy_m},       32'd0);
    check_eq({tag, "_word_done"},  {31'd0, word_done_m},  32'd0);
    check_eq({tag, "_load_ready"}, {31'd0, load_ready_m}, 32'd1);
    check_eq({tag, "_lsb_busy"},   {31'd0, busy_l},       32'd0);
    check_eq({tag, "_lsb_ready"},  {31'd0, load_ready_l}, 32'd1);
  endtask

  task automatic load_word(input logic [7:0] w);
    logic taken;
    taken      = 1'b0;
    load_valid = 1'b1;
    par_in     = w;
    for (int i = 0; i < 40 && !taken; i++) begin
      taken = load_ready_m;
      step();
    end
    load_valid = 1'b0;
    check_eq("load_accepted", {31'd0, taken}, 32'd1);
  endtask

  // Feeds load_q through the handshake and records bits, accept and done cycles
  task automatic run_words(input int max_cycles);
    int   cyc;
    logic taken;
    logic finished;
    cyc       = 0;
    finished  = 1'b0;
    bits      = 32'd0;
    nbits     = 0;
    first_bit = -1;
    last_bit  = -1;
    acc_cyc.delete();
    done_cyc.delete();
    while (cyc < max_cycles && !finished) begin
      if (load_q.size() > 0) begin
        load_valid = 1'b1;
        par_in     = load_q[0];
      end else begin
        load_valid = 1'b0;
      end
      taken = load_valid && load_ready_m;
      step();
      cyc++;
      if (taken) begin
        acc_cyc.push_back(cyc);
        void'(load_q.pop_front());
      end
      if (bit_valid_m) begin
        bits = {bits[30:0], data_out_m};
        nbits++;
        if (first_bit < 0) first_bit = cyc;
        last_bit = cyc;
      end
      if (word_done_m) done_cyc.push_back(cyc);
      if (load_q.size() == 0 && !busy_m && done_cyc.size() > 0) finished = 1'b1;
    end
    load_valid = 1'b0;
    check_eq("run_finished", {31'd0, finished}, 32'd1);
  endtask

  initial begin
    logic [7:0] pat;
    int         diff;

    rst_n      = 1'b0;
    load_valid = 1'b0;
    par_in     = 8'h00;
    shift_en   = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");

    rst_n    = 1'b1;
    shift_en = 1'b1;

    // Single word, both bit orders
    pat = 8'hB2;
    load_word(pat);
    check_eq("s1_ready_low", {31'd0, load_ready_m}, 32'd0);
    check_eq("s1_busy",      {31'd0, busy_m},       32'd1);
    check_eq("s1_not_yet",   {31'd0, bit_valid_m},  32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("s1_msb_bit",   {31'd0, data_out_m},  {31'd0, pat[7-i]});
      check_eq("s1_lsb_bit",   {31'd0, data_out_l},  {31'd0, pat[i]});
      check_eq("s1_bit_valid", {31'd0, bit_valid_m}, 32'd1);
    end
    step();
    check_eq("s1_valid_end", {31'd0, bit_valid_m}, 32'd0);
    check_eq("s1_done",      {31'd0, word_done_m}, 32'd1);
    check_eq("s1_done_lsb",  {31'd0, word_done_l}, 32'd1);
    check_eq("s1_idle_busy", {31'd0, busy_m},      32'd0);
    check_eq("s1_idle_line", {31'd0, data_out_m},  32'd0);
    step();
    check_eq("s1_done_pulse", {31'd0, word_done_m}, 32'd0);

    // Loopback into receiver model
    load_q = '{8'hD4};
    run_words(40);
    check_eq("s2_rx_word", {24'd0, rx_q}, 32'h0000_00D4);
    check_eq("s2_nbits",   nbits,         32'd8);

    // Back-to-back words
    load_q = '{8'hA5, 8'h3C};
    run_words(60);
    check_eq("s3_bits",     bits[15:0],               32'h0000_A53C);
    check_eq("s3_nbits",    nbits,                    32'd16);
    check_eq("s3_span",     last_bit - first_bit + 1, 32'd16);
    check_eq("s3_ndone",    done_cyc.size(),          32'd2);
    diff = (done_cyc.size() >= 2) ? done_cyc[1] - done_cyc[0] : -1;
    check_eq("s3_done_gap", diff,                     32'd8);
    diff = (acc_cyc.size() >= 2) ? acc_cyc[1] : -1;
    check_eq("s3_acc2",     diff,                     32'd3);

    // Stall after the second bit
    pat = 8'hF0;
    load_word(pat);
    step();
    check_eq("s4_bit7", {31'd0, data_out_m}, 32'd1);
    step();
    check_eq("s4_bit6", {31'd0, data_out_m}, 32'd1);
    shift_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("s4_stall_bit",   {31'd0, data_out_m},  32'd1);
      check_eq("s4_stall_valid", {31'd0, bit_valid_m}, 32'd1);
    end
    shift_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("s4_resume_bit", {31'd0, data_out_m}, {31'd0, pat[5-i]});
    end
    step();
    check_eq("s4_done",  {31'd0, word_done_m}, 32'd1);
    check_eq("s4_valid", {31'd0, bit_valid_m}, 32'd0);

    // Holding register full: third word waits for the second to enter the shifter
    load_q = '{8'h11, 8'h22, 8'h33};
    run_words(80);
    check_eq("s5_bits",  bits[23:0],               32'h0011_2233);
    check_eq("s5_nbits", nbits,                    32'd24);
    check_eq("s5_span",  last_bit - first_bit + 1, 32'd24);
    check_eq("s5_ndone", done_cyc.size(),          32'd3);
    diff = (acc_cyc.size() >= 3) ? acc_cyc[1] : -1;
    check_eq("s5_acc2",  diff,                     32'd3);
    diff = (acc_cyc.size() >= 3) ? acc_cyc[2] : -1;
    check_eq("s5_acc3",  diff,                     32'd11);

    // Asynchronous reset mid-word with a second word held
    pat = 8'h96;
    load_word(pat);
    load_word(8'h55);
    step();
    step();
    check_eq("s6_bit4", {31'd0, data_out_m}, {31'd0, pat[4]});
    check_eq("s6_held", {31'd0, load_ready_m}, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("s6_async");
    step();
    step();
    rst_n = 1'b1;
    load_q = '{8'h01};
    run_words(40);
    check_eq("s6_bits",  bits[7:0],       32'h0000_0001);
    check_eq("s6_nbits", nbits,           32'd8);
    check_eq("s6_ndone", done_cyc.size(), 32'd1);
    diff = (acc_cyc.size() >= 1) ? acc_cyc[0] : -1;
    check_eq("s6_acc",   diff,            32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
